// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard beside ID: produces the ID stall, per-source
// forwarding selects and a busy vector, and holds back younger writes that would overtake older ones.
module hazard_scoreboard #(
    parameter int NREGS   = 32,
    parameter int LAT_MAX = 4,
    parameter int NFWD    = 3,
    localparam int AW = $clog2(NREGS),
    localparam int DW = $clog2(LAT_MAX + NFWD),
    localparam int FW = $clog2(NFWD + 1),
    localparam int LW = $clog2(LAT_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic [1:0]       id_use,
    input  logic             id_wen,
    input  logic [AW-1:0]    id_dst,
    input  logic [LW-1:0]    id_lat,
    input  logic             flush,
    output logic             stall,
    output logic [FW-1:0]    rs1_fwd,
    output logic [FW-1:0]    rs2_fwd,
    output logic [NREGS-1:0] busy_vec
);

    localparam int NSLOT = 2 ** AW;
    localparam logic [DW-1:0] NFWD_D = DW'(NFWD);

    // Entries at or above NREGS exist only so any AW-bit index is in range; they stay zero.
    logic [DW-1:0] d_r [NSLOT];

    logic [LW-1:0] lat_s;
    logic [DW-1:0] load_s;
    logic [DW-1:0] d_rs1_s;
    logic [DW-1:0] d_rs2_s;
    logic [DW-1:0] d_dst_s;
    logic          rs1_used_s;
    logic          rs2_used_s;
    logic          dst_ok_s;
    logic          raw_s;
    logic          waw_s;
    logic          stall_s;
    logic          issue_s;

    function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] lat);
        logic [LW-1:0] res;
        res = lat;
        if (lat == {LW{1'b0}}) begin
            res = LW'(1);
        end else if (int'(lat) > LAT_MAX) begin
            res = LW'(LAT_MAX);
        end else begin
            res = lat;
        end
        return res;
    endfunction

    // Count 1..NFWD-1 means the value sits on bus NFWD-count; NFWD or more is not yet produced.
    function automatic logic [FW-1:0] fwd_sel(input logic [DW-1:0] d);
        logic [FW-1:0] sel;
        sel = {FW{1'b0}};
        if (d == {DW{1'b0}}) begin
            sel = {FW{1'b0}};
        end else if (d < NFWD_D) begin
            sel = FW'(NFWD_D - d);
        end else begin
            sel = {FW{1'b0}};
        end
        return sel;
    endfunction

    // Decode the ID instruction: clamped latency, source usage and scoreboard lookups.
    always_comb begin
        lat_s      = clamp_lat(id_lat);
        load_s     = DW'(int'(lat_s) + NFWD - 2);
        rs1_used_s = (id_use != 2'd0) && (id_rs1 != {AW{1'b0}});
        rs2_used_s = id_use[1] && (id_rs2 != {AW{1'b0}});
        dst_ok_s   = id_wen && (id_dst != {AW{1'b0}}) && (int'(id_dst) < NREGS);
        d_rs1_s    = d_r[id_rs1];
        d_rs2_s    = d_r[id_rs2];
        d_dst_s    = d_r[id_dst];
    end

    // Hazard detection; the source check always sees the pre-issue counts.
    always_comb begin
        raw_s   = 1'b0;
        waw_s   = 1'b0;
        stall_s = 1'b0;
        issue_s = 1'b0;
        if (id_valid && !flush) begin
            raw_s   = (rs1_used_s && (d_rs1_s >= NFWD_D)) ||
                      (rs2_used_s && (d_rs2_s >= NFWD_D));
            waw_s   = dst_ok_s && (d_dst_s >= NFWD_D) && (d_dst_s > load_s);
            stall_s = raw_s || waw_s;
            issue_s = dst_ok_s && !stall_s;
        end else begin
            raw_s   = 1'b0;
            waw_s   = 1'b0;
            stall_s = 1'b0;
            issue_s = 1'b0;
        end
    end

    // Output decode; unused sources and x0 always read the register file.
    always_comb begin
        stall   = stall_s;
        rs1_fwd = {FW{1'b0}};
        rs2_fwd = {FW{1'b0}};
        if (rs1_used_s) begin
            rs1_fwd = fwd_sel(d_rs1_s);
        end else begin
            rs1_fwd = {FW{1'b0}};
        end
        if (rs2_used_s) begin
            rs2_fwd = fwd_sel(d_rs2_s);
        end else begin
            rs2_fwd = {FW{1'b0}};
        end
    end

    // A register is busy while its value has not reached any forwarding bus.
    always_comb begin
        busy_vec = {NREGS{1'b0}};
        for (int r = 0; r < NREGS; r++) begin
            busy_vec[r] = (d_r[r] >= NFWD_D);
        end
    end

    // Countdown state: issue load takes priority over the per-cycle decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NSLOT; r++) begin
                d_r[r] <= {DW{1'b0}};
            end
        end else begin
            for (int r = 0; r < NSLOT; r++) begin
                if ((r == 0) || (r >= NREGS)) begin
                    d_r[r] <= {DW{1'b0}};
                end else if (issue_s && (id_dst == AW'(r))) begin
                    d_r[r] <= load_s;
                end else if (d_r[r] != {DW{1'b0}}) begin
                    d_r[r] <= d_r[r] - DW'(1);
                end else begin
                    d_r[r] <= d_r[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NREGS=32, LAT_MAX=4, NFWD=3); inputs change
// 1 time unit after the rising edge and outputs are checked on the falling edge.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [1:0]  id_use;
    logic        id_wen;
    logic [4:0]  id_dst;
    logic [2:0]  id_lat;
    logic        flush;
    logic        stall;
    logic [1:0]  rs1_fwd;
    logic [1:0]  rs2_fwd;
    logic [31:0] busy_vec;

    int checks;
    int failures;

    hazard_scoreboard #(.NREGS(32), .LAT_MAX(4), .NFWD(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .id_valid (id_valid),
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .id_use   (id_use),
        .id_wen   (id_wen),
        .id_dst   (id_dst),
        .id_lat   (id_lat),
        .flush    (flush),
        .stall    (stall),
        .rs1_fwd  (rs1_fwd),
        .rs2_fwd  (rs2_fwd),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [1:0] u, input logic w, input logic [4:0] d,
                         input logic [2:0] l, input logic f);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use = u;
        id_wen = w; id_dst = d; id_lat = l; flush = f;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    endtask

    task automatic to_check();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (8) next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 5'd5, 5'd6, 2'd2, 1'b1, 5'd5, 3'd4, 1'b0);
        #3;
        checks++;
        if (stall !== 1'b0 || rs1_fwd !== 2'd0 || rs2_fwd !== 2'd0 || busy_vec !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got stall=%b fwd=%0d/%0d busy=%h want 0 0/0 0",
                     stall, rs1_fwd, rs2_fwd, busy_vec);
        end
        idle();
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic alu_chain(input logic [4:0] r, input string tag);
        logic [1:0] exp_fwd [3];
        exp_fwd[0] = 2'd1; exp_fwd[1] = 2'd2; exp_fwd[2] = 2'd0;
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, r, 3'd1, 1'b0);
        to_check();
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL %s_issue_stall: got %b want 0", tag, stall);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive(1'b1, r, 5'd0, 2'd1, 1'b0, 5'd0, 3'd1, 1'b0);
            to_check();
            checks++;
            if (stall !== 1'b0 || rs1_fwd !== exp_fwd[c]) begin
                failures++;
                $display("FAIL %s_c%0d: got stall=%b rs1_fwd=%0d want stall=0 rs1_fwd=%0d",
                         tag, c + 1, stall, rs1_fwd, exp_fwd[c]);
            end
        end
        drain();
    endtask

    task automatic test_alu_chain();
        alu_chain(5'd5, "alu_chain");
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd6, 3'd2, 1'b0);
        next_cycle();
        drive(1'b1, 5'd1, 5'd6, 2'd2, 1'b0, 5'd0, 3'd1, 1'b0);
        to_check();
        checks++;
        if (stall !== 1'b1 || rs2_fwd !== 2'd0 || busy_vec !== 32'h0000_0040) begin
            failures++;
            $display("FAIL load_use_c1: got stall=%b rs2_fwd=%0d busy=%h want 1 0 00000040",
                     stall, rs2_fwd, busy_vec);
        end
        next_cycle();
        to_check();
        checks++;
        if (stall !== 1'b0 || rs2_fwd !== 2'd1 || rs1_fwd !== 2'd0) begin
            failures++;
            $display("FAIL load_use_c2: got stall=%b rs2_fwd=%0d rs1_fwd=%0d want 0 1 0",
                     stall, rs2_fwd, rs1_fwd);
        end
        drain();
    endtask

    task automatic test_multi_cycle();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd9, 3'd4, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            drive(1'b1, 5'd9, 5'd0, 2'd1, 1'b0, 5'd0, 3'd1, 1'b0);
            to_check();
            checks++;
            if (c < 4) begin
                if (stall !== 1'b1 || busy_vec[9] !== 1'b1) begin
                    failures++;
                    $display("FAIL multi_c%0d: got stall=%b busy9=%b want 1 1", c, stall, busy_vec[9]);
                end
            end else begin
                if (stall !== 1'b0 || rs1_fwd !== 2'd1 || busy_vec[9] !== 1'b0) begin
                    failures++;
                    $display("FAIL multi_c4: got stall=%b rs1_fwd=%0d busy9=%b want 0 1 0",
                             stall, rs1_fwd, busy_vec[9]);
                end
            end
        end
        drain();
    endtask

    task automatic test_waw();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd7, 3'd4, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd7, 3'd1, 1'b0);
            to_check();
            checks++;
            if (stall !== ((c < 4) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL waw_c%0d: got stall=%b want %b", c, stall, (c < 4) ? 1'b1 : 1'b0);
            end
        end
        next_cycle();
        drive(1'b1, 5'd7, 5'd0, 2'd1, 1'b0, 5'd0, 3'd1, 1'b0);
        to_check();
        checks++;
        if (stall !== 1'b0 || rs1_fwd !== 2'd1 || busy_vec !== 32'd0) begin
            failures++;
            $display("FAIL waw_c5: got stall=%b rs1_fwd=%0d busy=%h want 0 1 0", stall, rs1_fwd, busy_vec);
        end
        drain();
    endtask

    task automatic test_x0_unused();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd0, 3'd4, 1'b0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 2'd1, 1'b0, 5'd0, 3'd1, 1'b0);
        to_check();
        checks++;
        if (busy_vec !== 32'd0 || rs1_fwd !== 2'd0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL x0_dst: got busy=%h rs1_fwd=%0d stall=%b want 0 0 0", busy_vec, rs1_fwd, stall);
        end
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd8, 3'd4, 1'b0);
        next_cycle();
        drive(1'b1, 5'd1, 5'd8, 2'd1, 1'b0, 5'd0, 3'd1, 1'b0);
        to_check();
        checks++;
        if (stall !== 1'b0 || rs2_fwd !== 2'd0 || busy_vec !== 32'h0000_0100) begin
            failures++;
            $display("FAIL unused_rs2: got stall=%b rs2_fwd=%0d busy=%h want 0 0 00000100",
                     stall, rs2_fwd, busy_vec);
        end
        next_cycle();
        drive(1'b1, 5'd1, 5'd8, 2'd3, 1'b0, 5'd0, 3'd1, 1'b0);
        to_check();
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL use3_as_2: got stall=%b want 1", stall);
        end
        drain();
    endtask

    task automatic test_lat_clamp();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd12, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd12, 5'd0, 2'd1, 1'b1, 5'd13, 3'd7, 1'b0);
        to_check();
        checks++;
        if (stall !== 1'b0 || rs1_fwd !== 2'd1) begin
            failures++;
            $display("FAIL lat0_clamp: got stall=%b rs1_fwd=%0d want 0 1", stall, rs1_fwd);
        end
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            drive(1'b1, 5'd13, 5'd0, 2'd1, 1'b0, 5'd0, 3'd1, 1'b0);
            to_check();
            if (c == 2) begin
                checks++;
                if (stall !== 1'b1) begin
                    failures++;
                    $display("FAIL lat7_stall: got %b want 1", stall);
                end
            end else if (c == 5) begin
                checks++;
                if (stall !== 1'b0 || rs1_fwd !== 2'd1) begin
                    failures++;
                    $display("FAIL lat7_fwd: got stall=%b rs1_fwd=%0d want 0 1", stall, rs1_fwd);
                end
            end
        end
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd10, 3'd4, 1'b1);
        to_check();
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall: got %b want 0", stall);
        end
        next_cycle();
        idle();
        to_check();
        checks++;
        if (busy_vec !== 32'd0) begin
            failures++;
            $display("FAIL flush_no_issue: got busy=%h want 0", busy_vec);
        end
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd11, 3'd4, 1'b0);
        next_cycle();
        drive(1'b1, 5'd11, 5'd0, 2'd1, 1'b0, 5'd0, 3'd1, 1'b1);
        to_check();
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_raw: got stall=%b want 0", stall);
        end
        next_cycle();
        drive(1'b1, 5'd11, 5'd0, 2'd1, 1'b0, 5'd0, 3'd1, 1'b0);
        to_check();
        checks++;
        if (stall !== 1'b1 || busy_vec !== 32'h0000_0800) begin
            failures++;
            $display("FAIL flush_keeps_older: got stall=%b busy=%h want 1 00000800", stall, busy_vec);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 1'b1, 5'd3, 3'd3, 1'b0);
        next_cycle();
        drive(1'b1, 5'd3, 5'd0, 2'd1, 1'b0, 5'd0, 3'd1, 1'b0);
        to_check();
        checks++;
        if (busy_vec !== 32'h0000_0008 || stall !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got busy=%h stall=%b want 00000008 1", busy_vec, stall);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (busy_vec !== 32'd0 || stall !== 1'b0 || rs1_fwd !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: got busy=%h stall=%b rs1_fwd=%0d want 0 0 0",
                     busy_vec, stall, rs1_fwd);
        end
        idle();
        #1 reset = 1'b1;
        next_cycle();
        alu_chain(5'd3, "post_reset");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_multi_cycle();
        test_waw();
        test_x0_unused();
        test_lat_clamp();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
